tod_clock_counter: RTL
======================

# tod_clock_counter

Parametrised time-of-day counter: the successor to the team's fixed hours/minutes/seconds counter. It adds a built-in clock prescaler, run gating, a validated synchronous time load, a 12/24-hour display mode, and roll-over strobes. An optional daily alarm is also available. It sits between the board clock and the display/BCD driver blocks and feeds time fields and event strobes to them.

## Interface
- TICK_DIV, 50_000_000: enabled `Clk` cycles per second; legal range ≥1.
- Clk  in  1  system clock, rising-edge.
- Clr_n  in  1  asynchronous, active-low reset.
- En  in  1  run enable; gates the prescaler and time advance.
- Load  in  1  one-cycle load strobe for Ld_H/Ld_M/Ld_S.
- Ld_H, Ld_M, Ld_S  in  6 each  load values, binary, 24-hour.
- Mode12  in  1  selects 12-hour display (1) or 24-hour display (0).
- Al_Set  in  1  one-cycle strobe that latches Al_H/Al_M.
- Al_H, Al_M  in  6 each  alarm time, binary, 24-hour.
- Al_On  in  1  alarm armed.
- Alarm_Clr  in  1  clears Alarm.
- H, M, S  out  6 each  displayed time, binary.
- PM  out  1  high for internal hours 12–23; valid in both modes.
- Sec_Tick, Min_Tick, Day_Tick  out  1 each  one-cycle strobes.
- Load_Err  out  1  one-cycle strobe; flags a rejected Load or Al_Set.
- Alarm  out  1  sticky alarm flag.

## Operation
- Internal state: `hr24` (0–23), `min` (0–59), `sec` (0–59), `pre` (0..TICK_DIV-1), `al_h`, `al_m`.
- Prescaler:
  - Advances only while `En`=1 and resets to 0 at TICK_DIV-1.
  - When `pre`==TICK_DIV-1 and `En`=1, that edge also advances `sec`.
  - While `En`=0, `pre` and the time hold their values.
- Advance rules:
  - `sec` 59→0 carries into `min`; `min` 59→0 carries into `hr24`; `hr24` 23→0.
  - All fields update at the same edge.
  - Wrap compares are done on the current value before increment, so no out-of-range value is ever stored.
- Load:
  - Accepted only if Ld_H≤23, Ld_M≤59 and Ld_S≤59.
  - On acceptance: the time takes the load values and `pre`←0.
  - On rejection: nothing changes and Load_Err pulses.
  - Load is honoured regardless of `En`.
- Load in the same cycle as a second advance: Load wins, no strobes are produced, `pre`←0.
- Display mapping:
  - Mode12=0: H=`hr24`.
  - Mode12=1: `hr24` 0→12, 1–12 unchanged, 13–23→`hr24`-12.
  - The mapping is combinational from registered state; a Mode12 change is visible the same cycle.
  - M=`min`, S=`sec`.
- Strobes:
  - Sec_Tick: one cycle, on every accepted second advance.
  - Min_Tick: advance in which `sec` wrapped to 0.
  - Day_Tick: advance in which the time wrapped to 00:00:00.
  - Load never generates strobes.
- Alarm (ALARM_EN only):
  - Al_Set is validated like Load (Al_H≤23, Al_M≤59); a rejected Al_Set pulses Load_Err.
  - Alarm sets when a second advance produces `hr24`=`al_h`, `min`=`al_m`, `sec`=0 with Al_On=1.
  - Alarm clears on Alarm_Clr=1 or Al_On=0.
  - If set and clear occur in the same cycle, set wins.
  - Loading a matching time does not set Alarm.

## Timing
- Reset (Clr_n=0, immediate):
  - Time is 00:00:00; `pre`=0; `al_h`=`al_m`=0.
  - H=0 (Mode12=0) or H=12 (Mode12=1); M=S=0; PM=0.
  - All strobes, Load_Err and Alarm are 0.
- Reset release: the first second advance occurs after TICK_DIV enabled cycles.
- Strobe and Alarm latency: each strobe is a registered output, high in the cycle immediately after the advancing edge, coincident with the new S/M/H values. Alarm rises in that same cycle.
- Load/Al_Set latency: new values appear the cycle after the strobe. Load_Err is high the cycle after a rejected strobe.
- TICK_DIV=1: the time advances on every enabled cycle; strobes may be high on consecutive cycles.
- Clr_n asserted mid-second discards the partial prescale.

## Configuration
- ALARM_EN defined: `al_h`/`al_m` registers, compare logic and the sticky Alarm flag are built.
- ALARM_EN undefined:
  - Alarm ports stay present and Alarm is tied 0.
  - Al_Set, Al_H, Al_M, Al_On and Alarm_Clr are ignored; Al_Set never causes Load_Err.
  - No alarm registers are synthesised.

## Structure
- Package `clock_pkg`:
  - Constants: TW=6, SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
  - Function `to_h12(hr24)` returning {PM, H12}.
- Sub-module `tod_prescaler`: parameter TICK_DIV; ports Clk, Clr_n, En, Sync_Clr; output Adv. Sync_Clr is driven by an accepted Load.
- Top level: time registers, validation, strobes, display mapping and alarm.

## Test plan
- TICK_DIV=4, reset, En=1 for 240 cycles → 00:01:00; Min_Tick pulsed exactly once; Sec_Tick pulsed 60 times.
- Load 23:59:58, run 8 enabled cycles → 00:00:00; Day_Tick and Min_Tick pulse together once.
- Load Ld_H=24 (M=0, S=0) → Load_Err pulses one cycle; time unchanged.
- Mode12=1, separate loads:
  - 00:30:00 → H=12, PM=0.
  - 12:00:00 → H=12, PM=1.
  - 13:05:00 → H=1, PM=1.
- ALARM_EN, Al_Set 07:00, Al_On=1, load 06:59:59, run 4 cycles → Alarm=1 and held for 100 cycles; Alarm_Clr → 0 next cycle.
- Load asserted on the advancing cycle → loaded value shown, no Sec_Tick. Clr_n pulsed low at `pre`=2 → outputs zero immediately; next advance after 4 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared widths, field limits and the 24h->12h display helper for the TOD counter.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package clock_pkg;

    localparam int TW = 6;

    localparam logic [TW-1:0] SEC_MAX = TW'(59);
    localparam logic [TW-1:0] MIN_MAX = TW'(59);
    localparam logic [TW-1:0] HR_MAX  = TW'(23);
    localparam logic [TW-1:0] HR_NOON = TW'(12);

    // Returns {PM, H12}: midnight shows as 12, afternoon hours drop by 12.
    function automatic logic [TW:0] to_h12(input logic [TW-1:0] hr24);
        logic          pm;
        logic [TW-1:0] h12;
        pm = (hr24 >= HR_NOON);
        if (hr24 == '0) begin
            h12 = HR_NOON;
        end else if (hr24 > HR_NOON) begin
            h12 = hr24 - HR_NOON;
        end else begin
            h12 = hr24;
        end
        return {pm, h12};
    endfunction

endpackage

// File: rtl/tod_prescaler.sv
// Divides enabled Clk cycles down to a one-per-second advance pulse.
// Latency: Adv is combinational from the counter; first pulse TICK_DIV enabled cycles after clear.
// Backpressure: none; En=0 freezes the count, Sync_Clr restarts it from 0.
module tod_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clk,
    input  logic Clr_n,
    input  logic En,
    input  logic Sync_Clr,
    output logic Adv
);

    localparam int              PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic          w_last;

    assign w_last = (r_pre == LAST);
    assign Adv    = En && w_last;

    // Count enabled cycles; an accepted load realigns the second boundary.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_pre <= '0;
        end else if (Sync_Clr) begin
            r_pre <= '0;
        end else if (En) begin
            if (w_last) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tod_clock_counter.sv
// Time-of-day counter (hh:mm:ss) with prescaler, validated load, 12/24h display, strobes; optional alarm under `ALARM_EN.
// Latency: strobes, Load_Err and Alarm are registered, high the cycle after the advancing/loading edge; H/PM mapping is combinational.
// Backpressure: none; En gates advance, Load always wins over a coincident advance.
module tod_clock_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic          Clk,
    input  logic          Clr_n,
    input  logic          En,
    input  logic          Load,
    input  logic [TW-1:0] Ld_H,
    input  logic [TW-1:0] Ld_M,
    input  logic [TW-1:0] Ld_S,
    input  logic          Mode12,
    input  logic          Al_Set,
    input  logic [TW-1:0] Al_H,
    input  logic [TW-1:0] Al_M,
    input  logic          Al_On,
    input  logic          Alarm_Clr,
    output logic [TW-1:0] H,
    output logic [TW-1:0] M,
    output logic [TW-1:0] S,
    output logic          PM,
    output logic          Sec_Tick,
    output logic          Min_Tick,
    output logic          Day_Tick,
    output logic          Load_Err,
    output logic          Alarm
);

    logic [TW-1:0] r_hr;
    logic [TW-1:0] r_min;
    logic [TW-1:0] r_sec;
    logic          r_sec_tick;
    logic          r_min_tick;
    logic          r_day_tick;
    logic          r_load_err;

    logic          w_adv;
    logic          w_ld_ok;
    logic          w_ld_bad;
    logic          w_adv_acc;
    logic          w_sec_wrap;
    logic          w_min_wrap;
    logic          w_hr_wrap;
    logic [TW-1:0] w_nxt_sec;
    logic [TW-1:0] w_nxt_min;
    logic [TW-1:0] w_nxt_hr;
    logic [TW:0]   w_h12;
    logic          w_al_bad;

    // An out-of-range load is dropped whole; only a fully legal load clears the prescaler.
    assign w_ld_ok   = Load && (Ld_H <= HR_MAX) && (Ld_M <= MIN_MAX) && (Ld_S <= SEC_MAX);
    assign w_ld_bad  = Load && !w_ld_ok;
    assign w_adv_acc = w_adv && !w_ld_ok;

    tod_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .En       (En),
        .Sync_Clr (w_ld_ok),
        .Adv      (w_adv)
    );

    // Next time value, wrap tests on the current value so nothing out of range is ever stored.
    always_comb begin
        w_sec_wrap = (r_sec == SEC_MAX);
        w_min_wrap = (r_min == MIN_MAX);
        w_hr_wrap  = (r_hr  == HR_MAX);
        w_nxt_sec  = w_sec_wrap ? '0 : r_sec + 1'b1;
        w_nxt_min  = r_min;
        w_nxt_hr   = r_hr;
        if (w_sec_wrap) begin
            w_nxt_min = w_min_wrap ? '0 : r_min + 1'b1;
            if (w_min_wrap) begin
                w_nxt_hr = w_hr_wrap ? '0 : r_hr + 1'b1;
            end
        end
    end

    // Time registers: load has priority over the one-second advance.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_hr  <= '0;
            r_min <= '0;
            r_sec <= '0;
        end else if (w_ld_ok) begin
            r_hr  <= Ld_H;
            r_min <= Ld_M;
            r_sec <= Ld_S;
        end else if (w_adv_acc) begin
            r_hr  <= w_nxt_hr;
            r_min <= w_nxt_min;
            r_sec <= w_nxt_sec;
        end
    end

    // Event strobes and the reject flag, aligned with the new time values.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_sec_tick <= 1'b0;
            r_min_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= w_adv_acc;
            r_min_tick <= w_adv_acc && w_sec_wrap;
            r_day_tick <= w_adv_acc && w_sec_wrap && w_min_wrap && w_hr_wrap;
            r_load_err <= w_ld_bad || w_al_bad;
        end
    end

`ifdef ALARM_EN
    logic [TW-1:0] r_al_h;
    logic [TW-1:0] r_al_m;
    logic          r_alarm;
    logic          w_al_ok;
    logic          w_al_hit;

    assign w_al_ok  = Al_Set && (Al_H <= HR_MAX) && (Al_M <= MIN_MAX);
    assign w_al_bad = Al_Set && !w_al_ok;

    // Only a real advance can fire the alarm; landing on the time via Load does not.
    assign w_al_hit = w_adv_acc && Al_On && (w_nxt_hr == r_al_h) &&
                      (w_nxt_min == r_al_m) && (w_nxt_sec == '0);

    // Alarm time registers, updated only by a legal Al_Set.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_al_h <= '0;
            r_al_m <= '0;
        end else if (w_al_ok) begin
            r_al_h <= Al_H;
            r_al_m <= Al_M;
        end
    end

    // Sticky alarm flag: a hit beats a coincident clear or disarm.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_alarm <= 1'b0;
        end else if (w_al_hit) begin
            r_alarm <= 1'b1;
        end else if (Alarm_Clr || !Al_On) begin
            r_alarm <= 1'b0;
        end
    end

    assign Alarm = r_alarm;
`else
    logic w_alarm_unused;

    assign w_al_bad       = 1'b0;
    assign Alarm          = 1'b0;
    assign w_alarm_unused = ^{Al_Set, Al_H, Al_M, Al_On, Alarm_Clr};
`endif

    // Display mapping straight from registered state so a Mode12 flip shows immediately.
    assign w_h12    = to_h12(r_hr);
    assign H        = Mode12 ? w_h12[TW-1:0] : r_hr;
    assign PM       = w_h12[TW];
    assign M        = r_min;
    assign S        = r_sec;
    assign Sec_Tick = r_sec_tick;
    assign Min_Tick = r_min_tick;
    assign Day_Tick = r_day_tick;
    assign Load_Err = r_load_err;

endmodule
